alu_mc: RTL
===========

# alu_mc

Parametrised multi-cycle ALU with valid/ready handshakes on both the operand and result sides. It is the next generation of the team's two-stage pipelined 8-bit ALU and sits between the instruction issue logic and the writeback path. Width is configurable. Single-cycle operations sustain one result per clock. The two multiply commands run on an iterative shift-add unit, and the block stalls issue while a multiply is in progress. Downstream back-pressure is honoured without dropping results.

## Interface
- WIDTH, 8, operand width; power of two, ≥4
- SHW, $clog2(WIDTH), rotate-amount width (derived, not overridable)
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- CE  in  1  clock enable; when low, all state is frozen
- IN_VALID  in  1  operand beat valid
- IN_READY  out  1  operand beat accepted when IN_VALID && IN_READY
- MODE  in  1  1 = arithmetic, 0 = logical
- CMD  in  4  opcode
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid
- CIN  in  1  carry-in
- OPA, OPB  in  WIDTH  operands
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  result consumed when OUT_VALID && OUT_READY
- RES  out  2*WIDTH  result
- ERR, OFLOW, COUT, G, L, E, NEG, ZERO  out  1 each  flags

## Operation
**Arithmetic opcodes (MODE=1)**
- 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B, 8 CMP.
- 9 INC_MUL: RES = (OPA+1)*(OPB+1), with (WIDTH+1)-bit operands, truncated to 2*WIDTH.
- 10 SHL_MUL: RES = {OPA,1'b0}*OPB.
- 11 SADD, 12 SSUB: signed add and subtract.

**Logical opcodes (MODE=0)**
- 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B.
- 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B.
- 12 ROL_A_B, 13 ROR_A_B.

**Operand validity and errors**
- INC_A, DEC_A, NOT_A, SHR1_A and SHL1_A need INP_VALID[0].
- INC_B, DEC_B, NOT_B, SHR1_B and SHL1_B need INP_VALID[1].
- All other opcodes need INP_VALID=11.
- A missing operand or an undefined opcode gives ERR=1 with RES and all other flags 0.

**Arithmetic width rules**
- Add, sub, inc and dec results are WIDTH+1 bits, zero-extended into RES.
- COUT is the carry for add/inc and the borrow for sub/dec (A<B, or A==B with CIN for SUB_CIN).
- OFLOW equals COUT for unsigned operations.
- SADD/SSUB: OFLOW is two's-complement overflow. NEG = RES[WIDTH-1]. ZERO = (RES[WIDTH-1:0]==0). G/L/E come from the signed compare.
- CMP: unsigned compare, RES=0, exactly one of G/L/E is set.

**Logical width rules**
- Logical results are WIDTH bits, zero-extended.
- Rotates use amount OPB[SHW-1:0]. ERR=1 if any of OPB[WIDTH-1:SHW] is set; RES is still computed.

**Flags not defined for an opcode are 0.**

**State machine (IDLE, MUL)**
- IDLE → MUL on an accepted INC_MUL or SHL_MUL. Only these two opcodes enter MUL, and only when INP_VALID=11 and ERR=0.
- MUL runs one shift-add step per CE-enabled cycle, WIDTH+1 steps in total.
- MUL → IDLE when the last step completes and the output slot is free, meaning !OUT_VALID || OUT_READY. Otherwise MUL holds the finished product until the slot frees.

**Handshakes**
- IN_READY = CE && state==IDLE && (!OUT_VALID || OUT_READY).
- Single-cycle results load the output register on the accept edge.
- The output register holds RES and all flags stable while OUT_VALID && !OUT_READY.
- OUT_VALID falls on a consume edge unless a new result loads on the same edge.

## Timing
- Reset values: every output 0, state IDLE, multiplier registers 0.
- RST is honoured at any time, including mid-multiply; the in-flight result is discarded.
- Single-cycle opcodes: a beat accepted at edge n gives OUT_VALID from edge n+1. Throughput is 1 per cycle when OUT_READY=1.
- Multiply: a beat accepted at edge n gives OUT_VALID from edge n+WIDTH+1 if the output slot is free. IN_READY is 0 from edge n+1 until the return to IDLE.
- Consume and new accept on the same edge: the output register is replaced and OUT_VALID stays 1.
- CE=0: IN_READY=0, no state advances, and outputs hold their values. A consume with CE=0 is ignored.

## Structure
- Package alu_mc_pkg holds:
  - arithmetic and logical opcode localparams;
  - the state enum {IDLE, MUL};
  - the opcode operand-requirement function.
- Sub-module alu_mc_seqmul is an iterative shift-add multiplier.
  - Ports: start, a[WIDTH:0], b[WIDTH:0], done, product[2*WIDTH-1:0], en=CE.
  - The top level holds the single-cycle datapath, the FSM and the output register.

## Test plan
All scenarios use WIDTH=8.
- ADD, OPA=8'hFF, OPB=8'h01, INP_VALID=11 → at the next edge OUT_VALID=1, RES=16'h0100, COUT=1, OFLOW=1.
- INC_MUL, OPA=3, OPB=4 → IN_READY low for the multiply, RES=16'd20 exactly 9 cycles after accept. Also OPA=OPB=8'hFF → RES=16'h0000 (65536 truncated).
- SADD, 8'h7F+8'h01 → RES=16'h0080, OFLOW=1, NEG=1, G=1. SSUB, 8'h80−8'h01 → OFLOW=1.
- ROL_A_B, OPA=8'h81, OPB=8'h01 → RES=16'h0003, ERR=0. OPB=8'h11 → ERR=1.
- INP_VALID=01 with ADD → ERR=1, RES=0. Mid-multiply RST → all outputs 0 at once, IDLE, IN_READY=1 after release.
- Back-to-back AND, OR, XOR with OUT_READY held low for 3 cycles → the first result is held stable and IN_READY=0. All three results are delivered in order, one per cycle, after OUT_READY rises.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcodes, flag bit positions, FSM state and operand-requirement lookup for alu_mc
package alu_mc_pkg;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_ADD_CIN = 4'd2, A_SUB_CIN = 4'd3;
  localparam logic [3:0] A_INC_A = 4'd4, A_DEC_A = 4'd5, A_INC_B = 4'd6, A_DEC_B = 4'd7;
  localparam logic [3:0] A_CMP = 4'd8, A_INC_MUL = 4'd9, A_SHL_MUL = 4'd10, A_SADD = 4'd11, A_SSUB = 4'd12;
  localparam logic [3:0] L_AND = 4'd0, L_NAND = 4'd1, L_OR = 4'd2, L_NOR = 4'd3;
  localparam logic [3:0] L_XOR = 4'd4, L_XNOR = 4'd5, L_NOT_A = 4'd6, L_NOT_B = 4'd7;
  localparam logic [3:0] L_SHR1_A = 4'd8, L_SHL1_A = 4'd9, L_SHR1_B = 4'd10, L_SHL1_B = 4'd11;
  localparam logic [3:0] L_ROL = 4'd12, L_ROR = 4'd13;
  localparam int F_ERR = 7, F_OFLOW = 6, F_COUT = 5, F_G = 4, F_L = 3, F_E = 2, F_NEG = 1, F_ZERO = 0;
  typedef enum logic {IDLE, MUL} state_t;
  // returns {opcode defined, needs OPB, needs OPA}
  function automatic logic [2:0] op_need(input logic mode, input logic [3:0] cmd);
    return mode ? ((cmd == A_INC_A || cmd == A_DEC_A) ? 3'b101 :
                   (cmd == A_INC_B || cmd == A_DEC_B) ? 3'b110 :
                   (cmd <= A_SSUB) ? 3'b111 : 3'b000)
                : ((cmd == L_NOT_A || cmd == L_SHR1_A || cmd == L_SHL1_A) ? 3'b101 :
                   (cmd == L_NOT_B || cmd == L_SHR1_B || cmd == L_SHL1_B) ? 3'b110 :
                   (cmd <= L_ROR) ? 3'b111 : 3'b000);
  endfunction
endpackage

// File: rtl/alu_mc_seqmul.sv
// alu_mc_seqmul: iterative shift-add multiplier, one partial product per enabled cycle
module alu_mc_seqmul import alu_mc_pkg::*; #(parameter int WIDTH = 8) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic               start,
  input  logic [WIDTH:0]     a,
  input  logic [WIDTH:0]     b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 2);
  logic [2*WIDTH-1:0] r_acc, r_mcand, w_next;
  logic [WIDTH:0] r_mplier;
  logic [CW-1:0] r_cnt;
  // the last step is presented combinationally so the result lands on the step's own edge
  assign w_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign product = w_next;
  assign done = r_cnt <= CW'(1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_acc <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
      r_cnt <= '0;
    end else if (en && start) begin
      r_acc <= '0;
      r_mcand <= (2*WIDTH)'(a);
      r_mplier <= b;
      r_cnt <= CW'(WIDTH + 1);
    end else if (en && r_cnt != '0) begin
      r_acc <= w_next;
      r_mcand <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt <= r_cnt - CW'(1);
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes; multiplies stall issue while iterating
module alu_mc import alu_mc_pkg::*; #(parameter int WIDTH = 8) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic               MODE,
  input  logic [3:0]         CMD,
  input  logic [1:0]         INP_VALID,
  input  logic               CIN,
  input  logic [WIDTH-1:0]   OPA,
  input  logic [WIDTH-1:0]   OPB,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [2*WIDTH-1:0] RES,
  output logic               ERR,
  output logic               OFLOW,
  output logic               COUT,
  output logic               G,
  output logic               L,
  output logic               E,
  output logic               NEG,
  output logic               ZERO
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  state_t r_state, w_state_nxt;
  logic [2*WIDTH-1:0] r_res, w_res, w_prod;
  logic [7:0] r_flags, w_flags;
  logic [2:0] w_need;
  logic [WIDTH:0] w_a, w_b, w_au, w_ma, w_mb;
  logic [WIDTH-1:0] w_lo;
  logic r_out_valid, w_slot_free, w_acc, w_is_mul, w_start, w_mul_fin, w_done;
  logic w_bad, w_sgn, w_rot, w_cy;
  assign w_a = {1'b0, OPA};
  assign w_b = {1'b0, OPB};
  assign w_need = op_need(MODE, CMD);
  assign w_bad = !w_need[2] || ((INP_VALID & w_need[1:0]) != w_need[1:0]);
  assign w_sgn = MODE && (CMD == A_SADD || CMD == A_SSUB);
  assign w_rot = !MODE && (CMD == L_ROL || CMD == L_ROR);
  assign w_is_mul = MODE && (CMD == A_INC_MUL || CMD == A_SHL_MUL) && !w_bad;
  assign w_slot_free = !r_out_valid || OUT_READY;
  assign w_ma = CMD == A_INC_MUL ? w_a + ONE : {OPA, 1'b0};
  assign w_mb = CMD == A_INC_MUL ? w_b + ONE : w_b;
  alu_mc_seqmul #(.WIDTH(WIDTH)) u_mul (
    .CLK(CLK), .RST(RST), .en(CE), .start(w_start),
    .a(w_ma), .b(w_mb), .done(w_done), .product(w_prod)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= IDLE;
    else if (CE) r_state <= w_state_nxt;
  always_comb
    w_state_nxt = r_state == IDLE ? (w_start ? MUL : IDLE) : (w_mul_fin ? IDLE : MUL);
  always_comb begin
    IN_READY = CE && r_state == IDLE && w_slot_free;
    w_acc = IN_VALID && IN_READY;
    w_start = w_acc && w_is_mul;
    w_mul_fin = CE && r_state == MUL && w_done && w_slot_free;
  end
  always_comb
    case (CMD)
      A_ADD, A_SADD:        w_au = w_a + w_b;
      A_SUB, A_SSUB, A_CMP: w_au = w_a - w_b;
      A_ADD_CIN:            w_au = w_a + w_b + (WIDTH+1)'(CIN);
      A_SUB_CIN:            w_au = w_a - w_b - (WIDTH+1)'(CIN);
      A_INC_A:              w_au = w_a + ONE;
      A_DEC_A:              w_au = w_a - ONE;
      A_INC_B:              w_au = w_b + ONE;
      A_DEC_B:              w_au = w_b - ONE;
      default:              w_au = '0;
    endcase
  always_comb
    case (CMD)
      L_AND:    w_lo = OPA & OPB;
      L_NAND:   w_lo = ~(OPA & OPB);
      L_OR:     w_lo = OPA | OPB;
      L_NOR:    w_lo = ~(OPA | OPB);
      L_XOR:    w_lo = OPA ^ OPB;
      L_XNOR:   w_lo = ~(OPA ^ OPB);
      L_NOT_A:  w_lo = ~OPA;
      L_NOT_B:  w_lo = ~OPB;
      L_SHR1_A: w_lo = OPA >> 1;
      L_SHL1_A: w_lo = OPA << 1;
      L_SHR1_B: w_lo = OPB >> 1;
      L_SHL1_B: w_lo = OPB << 1;
      L_ROL:    w_lo = WIDTH'(({OPA, OPA} << OPB[SHW-1:0]) >> WIDTH);
      L_ROR:    w_lo = WIDTH'({OPA, OPA} >> OPB[SHW-1:0]);
      default:  w_lo = '0;
    endcase
  always_comb begin
    w_res = '0;
    w_flags = '0;
    w_cy = CMD != A_CMP && w_au[WIDTH];
    if (w_bad) w_flags[F_ERR] = 1'b1;
    else if (MODE) begin
      w_res = CMD == A_CMP ? '0 : (2*WIDTH)'(w_au);
      w_flags[F_COUT] = w_cy;
      w_flags[F_OFLOW] = w_sgn ? (OPA[WIDTH-1] ^ OPB[WIDTH-1] ^ (CMD == A_SADD)) && (w_au[WIDTH-1] != OPA[WIDTH-1]) : w_cy;
      w_flags[F_G] = CMD == A_CMP ? OPA > OPB : w_sgn && ($signed(OPA) > $signed(OPB));
      w_flags[F_L] = CMD == A_CMP ? OPA < OPB : w_sgn && ($signed(OPA) < $signed(OPB));
      w_flags[F_E] = (CMD == A_CMP || w_sgn) && OPA == OPB;
      w_flags[F_NEG] = w_sgn && w_au[WIDTH-1];
      w_flags[F_ZERO] = w_sgn && w_au[WIDTH-1:0] == '0;
    end else begin
      w_res = (2*WIDTH)'(w_lo);
      w_flags[F_ERR] = w_rot && |OPB[WIDTH-1:SHW];
    end
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_out_valid <= 1'b0;
      r_res <= '0;
      r_flags <= '0;
    end else if (CE) begin
      if (w_acc && !w_is_mul) begin
        r_out_valid <= 1'b1;
        r_res <= w_res;
        r_flags <= w_flags;
      end else if (w_mul_fin) begin
        r_out_valid <= 1'b1;
        r_res <= w_prod;
        r_flags <= '0;
      end else if (OUT_READY) r_out_valid <= 1'b0;
    end
  assign OUT_VALID = r_out_valid;
  assign RES = r_res;
  assign {ERR, OFLOW, COUT, G, L, E, NEG, ZERO} = r_flags;
endmodule
